// File: rtl/ct_mmu_iutlb_refill_ctrl.sv
// Instruction uTLB refill controller: miss detect, JTLB request/response, victim pick, entry update.
// Define IUTLB_PLRU_EN for tree pseudo-LRU replacement; otherwise a round-robin pointer is used.
module ct_mmu_iutlb_refill_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                 cpurst_b,
  input  logic                 utlb_entry_clk,
  input  logic                 ifu_mmu_va_vld,
  input  logic [26:0]          ifu_mmu_vpn,
  input  logic [15:0]          ifu_mmu_asid,
  input  logic                 ifu_mmu_flush,
  input  logic                 regs_utlb_clr,
  input  logic                 tlboper_utlb_clr,
  input  logic [ENTRY_NUM-1:0] utlb_entry_vld_vec,
  input  logic [ENTRY_NUM-1:0] utlb_entry_hit_vec,
  output logic                 iutlb_jtlb_req,
  output logic [26:0]          iutlb_jtlb_vpn,
  output logic [15:0]          iutlb_jtlb_asid,
  input  logic                 jtlb_iutlb_grant,
  input  logic                 jtlb_iutlb_rsp_vld,
  input  logic                 jtlb_iutlb_fault,
  input  logic [27:0]          jtlb_iutlb_ppn,
  input  logic [13:0]          jtlb_iutlb_flg,
  input  logic [2:0]           jtlb_iutlb_pgs,
  input  logic                 jtlb_iutlb_g,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic [26:0]          utlb_upd_vpn,
  output logic [27:0]          utlb_upd_ppn,
  output logic [13:0]          utlb_upd_flg,
  output logic [2:0]           utlb_upd_pgs,
  output logic [15:0]          utlb_upd_asid,
  output logic                 utlb_upd_g,
  output logic                 iutlb_ifu_miss_busy,
  output logic                 iutlb_ifu_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPD} state_t;

  state_t           state_q;
  logic             discard_q;
  logic             fault_q;
  logic [26:0]      req_vpn_q;
  logic [15:0]      req_asid_q;
  logic [IDX_W-1:0] victim_q;
  logic [26:0]      upd_vpn_q;
  logic [27:0]      upd_ppn_q;
  logic [13:0]      upd_flg_q;
  logic [2:0]       upd_pgs_q;
  logic [15:0]      upd_asid_q;
  logic             upd_g_q;

  logic                 clr, kill, eff_hit, miss, upd_fire, any_inv;
  logic [ENTRY_NUM-1:0] eff_vec;
  logic [IDX_W-1:0]     inv_idx, pol_victim;

  assign clr      = regs_utlb_clr | tlboper_utlb_clr;
  assign kill     = ifu_mmu_flush | clr;
  assign eff_vec  = utlb_entry_vld_vec & utlb_entry_hit_vec;
  assign eff_hit  = |eff_vec;
  assign miss     = ifu_mmu_va_vld & ~eff_hit & (state_q == IDLE) & ~kill;
  // clr wins at the entry, so the write pulse is withheld the same cycle
  assign upd_fire = (state_q == UPD) & ~clr;
  assign any_inv  = ~&utlb_entry_vld_vec;

  always_comb begin
    inv_idx = '0;
    for (int i = ENTRY_NUM-1; i >= 0; i--)
      if (!utlb_entry_vld_vec[i]) inv_idx = IDX_W'(i);
  end

`ifdef IUTLB_PLRU_EN
  logic [ENTRY_NUM-1:1] plru_q, plru_d;
  logic [IDX_W-1:0]     hit_idx;

  // Heap-ordered tree: node n has children 2n and 2n+1; a bit of 1 steers the victim right.
  function automatic logic [ENTRY_NUM-1:1] plru_touch(input logic [ENTRY_NUM-1:1] t,
                                                      input logic [IDX_W-1:0] e);
    logic [IDX_W-1:0] n;
    plru_touch = t;
    n = IDX_W'(1);
    for (int l = IDX_W-1; l >= 0; l--) begin
      plru_touch[n] = ~e[l];
      n = IDX_W'({n, e[l]});
    end
  endfunction

  function automatic logic [IDX_W-1:0] plru_pick(input logic [ENTRY_NUM-1:1] t);
    logic [IDX_W-1:0] n;
    plru_pick = '0;
    n = IDX_W'(1);
    for (int l = IDX_W-1; l >= 0; l--) begin
      plru_pick[l] = t[n];
      n = IDX_W'({n, t[n]});
    end
  endfunction

  always_comb begin
    hit_idx = '0;
    for (int i = ENTRY_NUM-1; i >= 0; i--)
      if (eff_vec[i]) hit_idx = IDX_W'(i);
  end

  always_comb begin
    plru_d = plru_q;
    if (eff_hit)  plru_d = plru_touch(plru_d, hit_idx);
    if (upd_fire) plru_d = plru_touch(plru_d, victim_q);
  end

  assign pol_victim = plru_pick(plru_q);

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b)
    if (!cpurst_b) plru_q <= '0;
    else           plru_q <= plru_d;
`else
  logic [IDX_W-1:0] rr_q, rr_d;

  assign rr_d       = upd_fire ? rr_q + 1'b1 : rr_q;
  assign pol_victim = rr_q;

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b)
    if (!cpurst_b) rr_q <= '0;
    else           rr_q <= rr_d;
`endif

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= IDLE;
      discard_q  <= 1'b0;
      fault_q    <= 1'b0;
      req_vpn_q  <= '0;
      req_asid_q <= '0;
      victim_q   <= '0;
      upd_vpn_q  <= '0;
      upd_ppn_q  <= '0;
      upd_flg_q  <= '0;
      upd_pgs_q  <= '0;
      upd_asid_q <= '0;
      upd_g_q    <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
          if (miss) begin
            state_q    <= REQ;
            req_vpn_q  <= ifu_mmu_vpn;
            req_asid_q <= ifu_mmu_asid;
          end
        end
        REQ: begin
          if (jtlb_iutlb_grant) begin
            state_q   <= WAIT;
            discard_q <= kill;
          end else if (kill) begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (jtlb_iutlb_rsp_vld) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            // a kill arriving with the response discards it too
            if (!(discard_q || kill)) begin
              if (jtlb_iutlb_fault) begin
                fault_q <= 1'b1;
              end else begin
                state_q    <= UPD;
                victim_q   <= any_inv ? inv_idx : pol_victim;
                upd_vpn_q  <= req_vpn_q;
                upd_asid_q <= req_asid_q;
                upd_ppn_q  <= jtlb_iutlb_ppn;
                upd_flg_q  <= jtlb_iutlb_flg;
                upd_pgs_q  <= jtlb_iutlb_pgs;
                upd_g_q    <= jtlb_iutlb_g;
              end
            end
          end else if (kill) begin
            discard_q <= 1'b1;
          end
        end
        UPD: begin
          state_q   <= IDLE;
          discard_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    utlb_entry_upd = '0;
    if (upd_fire) utlb_entry_upd[victim_q] = 1'b1;
  end

  assign iutlb_jtlb_req      = (state_q == REQ);
  assign iutlb_jtlb_vpn      = req_vpn_q;
  assign iutlb_jtlb_asid     = req_asid_q;
  assign iutlb_ifu_miss_busy = (state_q != IDLE);
  assign iutlb_ifu_fault     = fault_q;
  assign utlb_upd_vpn        = upd_vpn_q;
  assign utlb_upd_ppn        = upd_ppn_q;
  assign utlb_upd_flg        = upd_flg_q;
  assign utlb_upd_pgs        = upd_pgs_q;
  assign utlb_upd_asid       = upd_asid_q;
  assign utlb_upd_g          = upd_g_q;

endmodule

// File: tb/tb_ct_mmu_iutlb_refill_ctrl.sv
// Randomized scoreboard bench for ct_mmu_iutlb_refill_ctrl with an entry/replacement model.
module tb_ct_mmu_iutlb_refill_ctrl;
  localparam int EN  = 8;
  localparam int LOG = $clog2(EN);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          va_vld, flush, regs_clr, tlb_clr, grant, rsp_vld, rsp_fault, rsp_g;
  logic [26:0]   va_vpn;
  logic [15:0]   va_asid;
  logic [EN-1:0] vld_vec, hit_vec;
  logic [27:0]   rsp_ppn;
  logic [13:0]   rsp_flg;
  logic [2:0]    rsp_pgs;
  logic          req, busy, fault, upd_g;
  logic [26:0]   req_vpn, upd_vpn;
  logic [15:0]   req_asid, upd_asid;
  logic [EN-1:0] upd;
  logic [27:0]   upd_ppn;
  logic [13:0]   upd_flg;
  logic [2:0]    upd_pgs;

  always #5 clk = ~clk;

  ct_mmu_iutlb_refill_ctrl #(.ENTRY_NUM(EN)) dut (
    .cpurst_b(rst_n), .utlb_entry_clk(clk),
    .ifu_mmu_va_vld(va_vld), .ifu_mmu_vpn(va_vpn), .ifu_mmu_asid(va_asid),
    .ifu_mmu_flush(flush), .regs_utlb_clr(regs_clr), .tlboper_utlb_clr(tlb_clr),
    .utlb_entry_vld_vec(vld_vec), .utlb_entry_hit_vec(hit_vec),
    .iutlb_jtlb_req(req), .iutlb_jtlb_vpn(req_vpn), .iutlb_jtlb_asid(req_asid),
    .jtlb_iutlb_grant(grant), .jtlb_iutlb_rsp_vld(rsp_vld), .jtlb_iutlb_fault(rsp_fault),
    .jtlb_iutlb_ppn(rsp_ppn), .jtlb_iutlb_flg(rsp_flg), .jtlb_iutlb_pgs(rsp_pgs),
    .jtlb_iutlb_g(rsp_g),
    .utlb_entry_upd(upd), .utlb_upd_vpn(upd_vpn), .utlb_upd_ppn(upd_ppn),
    .utlb_upd_flg(upd_flg), .utlb_upd_pgs(upd_pgs), .utlb_upd_asid(upd_asid),
    .utlb_upd_g(upd_g), .iutlb_ifu_miss_busy(busy), .iutlb_ifu_fault(fault)
  );

  typedef struct { int kind; logic [127:0] data; } ev_t; // 0 req, 1 upd, 2 fault
  ev_t sb[$];
  int  checks = 0, errors = 0;

  // reference model: entry valid bits plus replacement state
  logic [EN-1:0] m_vld;
  int            m_rr;
  bit            m_tree[EN];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [127:0] d);
    ev_t e;
    e.kind = k; e.data = d;
    sb.push_back(e);
  endtask

  task automatic touch(input int e);
    for (int k = 0; k < LOG; k++)
      m_tree[(1 << k) + (e >> (LOG - k))] = !((e >> (LOG - 1 - k)) & 1);
  endtask

  function automatic int pick();
    int n;
    for (int i = 0; i < EN; i++) if (!m_vld[i]) return i;
`ifdef IUTLB_PLRU_EN
    n = 1;
    for (int k = 0; k < LOG; k++) n = 2 * n + int'(m_tree[n]);
    return n - EN;
`else
    n = m_rr;
    return n;
`endif
  endfunction

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < EN; i++) m_tree[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an event
  logic mon_prev = 1'b0;
  task automatic pop(input int k, input logic [127:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event", 128'(k), 128'hdead);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", 128'(k), 128'(e.kind));
      chk("sb_data", d, e.data);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req && !mon_prev) pop(0, 128'({req_vpn, req_asid}));
        if (|upd) pop(1, 128'({upd, upd_vpn, upd_ppn, upd_flg, upd_pgs, upd_asid, upd_g}));
        if (fault) pop(2, 128'(0));
      end
      mon_prev = req;
    end
  end

  // mode: 0 normal, 1 fault, 2 flush in WAIT, 3 clr in UPD, 4 flush in REQ
  task automatic refill(input logic [26:0] vpn, input logic [15:0] asid,
                        input int gd, input int wd, input int mode);
    int v;
    va_vld = 1'b1; va_vpn = vpn; va_asid = asid; hit_vec = '0; vld_vec = m_vld;
    push(0, 128'({vpn, asid}));
    step();
    va_vld = 1'b0; va_vpn = 27'($urandom);
    #1 chk("req_latency", 128'(req), 128'(1));
    if (mode == 4) begin
      flush = 1'b1; step(); flush = 1'b0;
      #1 chk("req_drop_flush", 128'({req, busy}), 128'(0));
      return;
    end
    repeat (gd) step();
    grant = 1'b1; step(); grant = 1'b0;
    #1 chk("req_fall_after_grant", 128'({req, busy}), 128'(2'b01));
    if (mode == 2) begin flush = 1'b1; step(); flush = 1'b0; end
    repeat (wd) step();
    rsp_vld = 1'b1; rsp_fault = (mode == 1);
    rsp_ppn = 28'($urandom); rsp_flg = 14'($urandom); rsp_pgs = 3'($urandom); rsp_g = 1'($urandom);
    v = pick();
    if (mode == 0) push(1, 128'({8'(1 << v), vpn, rsp_ppn, rsp_flg, rsp_pgs, asid, rsp_g}));
    if (mode == 1) push(2, 128'(0));
    step();
    rsp_vld = 1'b0; rsp_fault = 1'b0;
    if (mode == 3) tlb_clr = 1'b1;
    #1;
    chk("upd_latency", 128'(upd), (mode == 0) ? 128'(1 << v) : 128'(0));
    chk("fault_latency", 128'(fault), 128'(mode == 1));
    if (mode == 0) begin m_vld[v] = 1'b1; m_rr = (m_rr + 1) % EN; touch(v); end
    if (mode == 3) m_vld = '0;
    step();
    tlb_clr = 1'b0; vld_vec = m_vld;
    #1 chk("busy_back_idle", 128'({busy, upd}), 128'(0));
  endtask

  task automatic hit(input logic [EN-1:0] vec);
    int lo;
    lo = 0;
    for (int i = EN-1; i >= 0; i--) if (vec[i]) lo = i;
    va_vld = 1'b1; hit_vec = vec; vld_vec = m_vld; va_vpn = 27'($urandom);
    step();
    va_vld = 1'b0; hit_vec = '0;
    touch(lo);
    #1 chk("hit_no_req", 128'({req, busy}), 128'(0));
  endtask

  task automatic clr_idle();
    regs_clr = 1'b1; step(); regs_clr = 1'b0;
    m_vld = '0; vld_vec = '0;
    #1 chk("clr_idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [EN-1:0] hv;
    int op;
    va_vld = 0; flush = 0; regs_clr = 0; tlb_clr = 0; grant = 0; rsp_vld = 0; rsp_fault = 0;
    rsp_g = 0; va_vpn = '0; va_asid = '0; vld_vec = '0; hit_vec = '0;
    rsp_ppn = '0; rsp_flg = '0; rsp_pgs = '0;
    m_vld = '0; model_reset();
    #3;
    chk("rst_ctl", 128'({req, busy, fault, upd}), 128'(0));
    chk("rst_payload", 128'({upd_vpn, upd_ppn, upd_flg, upd_pgs, upd_asid, upd_g}), 128'(0));
    chk("rst_req_regs", 128'({req_vpn, req_asid}), 128'(0));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    refill(27'h1234, 16'h0042, 0, 1, 0);       // cold miss -> entry 0
    refill(27'h2000, 16'h0042, 1, 0, 1);       // fault
    refill(27'h3000, 16'h0042, 0, 2, 2);       // flush in WAIT
    refill(27'h4000, 16'h0042, 2, 1, 3);       // clr in UPD
    for (int i = 0; i < EN; i++) refill(27'($urandom), 16'($urandom), i % 3, i % 2, 0);
    for (int i = 0; i < EN-1; i++) hit(8'(1 << i));
    refill(27'h5555, 16'h0007, 0, 0, 0);       // all valid: policy victim

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 11);
      if (op < 4 && m_vld != 0) begin
        hv = 8'($urandom) & m_vld;
        if (hv == 0) hv = m_vld & (~m_vld + 1'b1);
        hit(hv);
      end else if (op == 4) clr_idle();
      else if (op < 8) refill(27'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      else refill(27'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), op - 7);
    end

    // async reset while requesting
    va_vld = 1'b1; va_vpn = 27'h6789; va_asid = 16'h11; vld_vec = m_vld;
    push(0, 128'({27'h6789, 16'h11}));
    step(); va_vld = 1'b0;
    #1 chk("rst_mid_req_pre", 128'(req), 128'(1));
    @(negedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_mid_req_now", 128'({req, busy}), 128'(0));
    model_reset();
    step(); rst_n = 1'b1;
    grant = 1'b1; step(); grant = 1'b0;
    rsp_vld = 1'b1; rsp_ppn = 28'habc; step(); rsp_vld = 1'b0;
    #1 chk("rst_late_rsp", 128'({upd, fault, busy}), 128'(0));
    chk("rst_payload_clr", 128'(upd_ppn), 128'(0));
    refill(27'h7777, 16'h0001, 1, 1, 0);

    repeat (3) step();
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
